// File: rtl/point_collector.sv
// -----------------------------------------------------------------------------
// point_collector
//
// Per-frame collector of thresholded pixel coordinates for the k-means path.
// Every masked pixel's {hcount, vcount} is written into one bank of a
// ping-pong point BRAM. When the frame ends, the finished bank is handed to
// the k-means controller through a valid/ack handshake. Capture of the next
// frame continues in the other bank, so the consumer always reads a stable,
// complete frame.
//
// Ports:
//   clk_in              camera-domain clock
//   rst_in              synchronous, active-low reset
//   hcount_in [8:0]     pixel column, aligned with mask_in
//   vcount_in [7:0]     pixel row, aligned with mask_in
//   valid_in            pixel strobe
//   mask_in             threshold result for this pixel
//   wr_en_out           point BRAM write enable (one-cycle pulse per point)
//   wr_addr_out         {bank, index}
//   wr_data_out [16:0]  {hcount, vcount}
//   frame_valid_out     read bank holds an unconsumed frame
//   frame_bank_out      bank that k-means should read
//   frame_count_out     number of points in the read bank
//   frame_overflow_out  read-bank frame had more than MAX_POINTS masked pixels
//   frame_ack_in        consumer has finished with the read bank
//   dropped_frames_out  saturating count of completed frames that were discarded
// -----------------------------------------------------------------------------
module point_collector #(
    parameter int H_ACTIVE   = 320,
    parameter int V_ACTIVE   = 180,
    parameter int MAX_POINTS = 14400,
    parameter int IDX_W      = 14
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [8:0]       hcount_in,
    input  logic [7:0]       vcount_in,
    input  logic             valid_in,
    input  logic             mask_in,
    output logic             wr_en_out,
    output logic [IDX_W:0]   wr_addr_out,
    output logic [16:0]      wr_data_out,
    output logic             frame_valid_out,
    output logic             frame_bank_out,
    output logic [IDX_W:0]   frame_count_out,
    output logic             frame_overflow_out,
    input  logic             frame_ack_in,
    output logic [7:0]       dropped_frames_out
);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        HANDOFF
    } state_t;

    localparam logic [8:0]     H_LAST  = 9'(H_ACTIVE - 1);
    localparam logic [7:0]     V_LAST  = 8'(V_ACTIVE - 1);
    localparam logic [IDX_W:0] MAX_CNT = (IDX_W + 1)'(MAX_POINTS);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W + 1)'(1);

    state_t         state;
    state_t         state_nxt;

    logic           wbank;
    logic [IDX_W:0] count;
    logic           ovf;

    // Pixel classification
    logic           start_px;
    logic           end_px;

    // Per-cycle actions decoded from state and inputs
    logic           capture;
    logic           restart;
    logic [IDX_W:0] cnt_base;
    logic           ovf_base;
    logic           take;
    logic           do_write;
    logic           set_ovf;
    logic           bank_free;
    logic           do_handoff;
    logic           do_drop;
    logic           do_release;

    assign start_px = valid_in && (hcount_in == 9'd0)   && (vcount_in == 8'd0);
    assign end_px   = valid_in && (hcount_in == H_LAST) && (vcount_in == V_LAST);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every clocked assignment uses <= so all registers update from the
    // values sampled at the same edge, regardless of statement order.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: the default assignment at the top of each combinational block
    // guarantees every path drives every signal, so no latch is inferred.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // A one-pixel frame is both start and end; go straight to handoff.
                if (start_px) begin
                    state_nxt = end_px ? HANDOFF : COLLECT;
                end
            end
            COLLECT: begin
                if (end_px) begin
                    state_nxt = HANDOFF;
                end
            end
            HANDOFF: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output / action decode
    // -------------------------------------------------------------------------
    always_comb begin
        capture    = 1'b0;
        restart    = 1'b0;
        cnt_base   = count;
        ovf_base   = ovf;
        take       = 1'b0;
        do_write   = 1'b0;
        set_ovf    = 1'b0;
        bank_free  = !frame_valid_out || frame_ack_in;
        do_handoff = 1'b0;
        do_drop    = 1'b0;
        do_release = 1'b0;

        // The frame start pixel is processed like any collected pixel, but
        // against an empty frame: this covers both the IDLE entry and a
        // truncated frame restarting while in COLLECT.
        capture = (state == COLLECT) || ((state == IDLE) && start_px);
        restart = capture && start_px;
        if (restart) begin
            cnt_base = '0;
            ovf_base = 1'b0;
        end

        take     = capture && valid_in && mask_in;
        do_write = take && (cnt_base < MAX_CNT);
        set_ovf  = take && !(cnt_base < MAX_CNT);

        do_handoff = (state == HANDOFF) && bank_free;
        do_drop    = (state == HANDOFF) && !bank_free;
        // Ack during HANDOFF is absorbed by the handoff itself.
        do_release = (state != HANDOFF) && frame_valid_out && frame_ack_in;
    end

    // -------------------------------------------------------------------------
    // Datapath and output registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            wbank              <= 1'b0;
            count              <= '0;
            ovf                <= 1'b0;
            wr_en_out          <= 1'b0;
            wr_addr_out        <= '0;
            wr_data_out        <= '0;
            frame_valid_out    <= 1'b0;
            frame_bank_out     <= 1'b0;
            frame_count_out    <= '0;
            frame_overflow_out <= 1'b0;
            dropped_frames_out <= '0;
        end else begin
            wr_en_out <= do_write;
            if (do_write) begin
                wr_addr_out <= {wbank, cnt_base[IDX_W-1:0]};
                wr_data_out <= {hcount_in, vcount_in};
            end

            if (capture) begin
                count <= do_write ? (cnt_base + CNT_ONE) : cnt_base;
                ovf   <= ovf_base | set_ovf;
            end

            if (do_handoff) begin
                frame_bank_out     <= wbank;
                frame_count_out    <= count;
                frame_overflow_out <= ovf;
                frame_valid_out    <= 1'b1;
                wbank              <= !wbank;
            end else if (do_release) begin
                frame_valid_out <= 1'b0;
            end

            if (do_drop && (dropped_frames_out != 8'hFF)) begin
                dropped_frames_out <= dropped_frames_out + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_point_collector.sv
// -----------------------------------------------------------------------------
// tb_point_collector
//
// Scoreboard bench for point_collector. Stimulus tasks push the expected BRAM
// writes and frame handoffs into queues; an independent monitor pops and
// compares them whenever the DUT presents a write or a new read bank.
// A reduced frame geometry keeps many full frames within a short run.
// -----------------------------------------------------------------------------
module tb_point_collector;

    localparam int H    = 20;
    localparam int V    = 10;
    localparam int MAXP = 150;
    localparam int IW   = 8;

    localparam int MODE_SPARSE = 0;   // mask only at (5,7) and (H-1,V-1)
    localparam int MODE_ALL    = 1;   // every pixel masked

    logic          clk_in = 1'b0;
    logic          rst_in;
    logic [8:0]    hcount_in;
    logic [7:0]    vcount_in;
    logic          valid_in;
    logic          mask_in;
    logic          wr_en_out;
    logic [IW:0]   wr_addr_out;
    logic [16:0]   wr_data_out;
    logic          frame_valid_out;
    logic          frame_bank_out;
    logic [IW:0]   frame_count_out;
    logic          frame_overflow_out;
    logic          frame_ack_in;
    logic [7:0]    dropped_frames_out;

    typedef struct packed {
        logic [IW:0] addr;
        logic [16:0] data;
    } wr_t;

    typedef struct packed {
        logic        bank;
        logic [IW:0] count;
        logic        ovf;
    } ho_t;

    wr_t wr_q[$];
    ho_t ho_q[$];

    int checks = 0;
    int errors = 0;

    always #5 clk_in = ~clk_in;

    point_collector #(
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .MAX_POINTS (MAXP),
        .IDX_W      (IW)
    ) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .hcount_in          (hcount_in),
        .vcount_in          (vcount_in),
        .valid_in           (valid_in),
        .mask_in            (mask_in),
        .wr_en_out          (wr_en_out),
        .wr_addr_out        (wr_addr_out),
        .wr_data_out        (wr_data_out),
        .frame_valid_out    (frame_valid_out),
        .frame_bank_out     (frame_bank_out),
        .frame_count_out    (frame_count_out),
        .frame_overflow_out (frame_overflow_out),
        .frame_ack_in       (frame_ack_in),
        .dropped_frames_out (dropped_frames_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Monitor: compares every presented write and every new read bank
    // -------------------------------------------------------------------------
    initial begin
        logic pv;
        logic pb;
        wr_t  ew;
        ho_t  eh;
        pv = 1'b0;
        pb = 1'b0;
        forever begin
            @(negedge clk_in);
            if (wr_en_out === 1'b1) begin
                if (wr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: addr %0h data %0h, expected no write",
                             wr_addr_out, wr_data_out);
                end else begin
                    ew = wr_q.pop_front();
                    check("wr_addr", 32'(wr_addr_out), 32'(ew.addr));
                    check("wr_data", 32'(wr_data_out), 32'(ew.data));
                end
            end
            if (frame_valid_out === 1'b1 && (!pv || frame_bank_out !== pb)) begin
                if (ho_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_handoff: bank %0d count %0d ovf %0d, expected none",
                             frame_bank_out, frame_count_out, frame_overflow_out);
                end else begin
                    eh = ho_q.pop_front();
                    check("handoff_bank",  32'(frame_bank_out),     32'(eh.bank));
                    check("handoff_count", 32'(frame_count_out),    32'(eh.count));
                    check("handoff_ovf",   32'(frame_overflow_out), 32'(eh.ovf));
                end
            end
            pv = frame_valid_out;
            pb = frame_bank_out;
        end
    end

    // Watchdog: the stimulus is finite, this only guards against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    // -------------------------------------------------------------------------
    // Stimulus helpers
    // -------------------------------------------------------------------------
    function automatic logic mask_of(input int mode, input int h, input int v);
        if (mode == MODE_ALL) return 1'b1;
        return ((h == 5) && (v == 7)) || ((h == H - 1) && (v == V - 1));
    endfunction

    task automatic blank(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            valid_in  = 1'b0;
            mask_in   = 1'b0;
            hcount_in = '0;
            vcount_in = '0;
        end
    endtask

    task automatic ack_pulse();
        @(negedge clk_in);
        frame_ack_in = 1'b1;
        valid_in     = 1'b0;
        mask_in      = 1'b0;
        @(negedge clk_in);
        frame_ack_in = 1'b0;
    endtask

    // Drives the first npix pixels of a frame in raster order. Masked pixels
    // are expected at consecutive indices of the given bank until the bank
    // capacity is reached.
    task automatic run_pixels(input int mode, input logic bank, input int npix);
        int idx;
        int h;
        int v;
        logic m;
        idx = 0;
        for (int p = 0; p < npix; p++) begin
            h = p % H;
            v = p / H;
            m = mask_of(mode, h, v);
            if (m && idx < MAXP) begin
                wr_q.push_back(wr_t'{addr: {bank, IW'(idx)}, data: {9'(h), 8'(v)}});
            end
            if (m) idx++;
            @(negedge clk_in);
            valid_in  = 1'b1;
            hcount_in = 9'(h);
            vcount_in = 8'(v);
            mask_in   = m;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"},       32'(wr_en_out),          32'd0);
        check({tag, "_wr_addr"},     32'(wr_addr_out),        32'd0);
        check({tag, "_wr_data"},     32'(wr_data_out),        32'd0);
        check({tag, "_valid"},       32'(frame_valid_out),    32'd0);
        check({tag, "_bank"},        32'(frame_bank_out),     32'd0);
        check({tag, "_count"},       32'(frame_count_out),    32'd0);
        check({tag, "_ovf"},         32'(frame_overflow_out), 32'd0);
        check({tag, "_dropped"},     32'(dropped_frames_out), 32'd0);
    endtask

    // -------------------------------------------------------------------------
    // Directed sequence
    // -------------------------------------------------------------------------
    initial begin
        rst_in       = 1'b0;
        valid_in     = 1'b0;
        mask_in      = 1'b0;
        hcount_in    = '0;
        vcount_in    = '0;
        frame_ack_in = 1'b0;

        repeat (3) @(negedge clk_in);
        check_all_zero("reset");
        rst_in = 1'b1;
        blank(2);

        // A: sparse frame, handed off on bank 0 two cycles after the end pixel
        ho_q.push_back(ho_t'{bank: 1'b0, count: 9'd2, ovf: 1'b0});
        run_pixels(MODE_SPARSE, 1'b0, H * V);
        @(negedge clk_in);
        valid_in = 1'b0;
        mask_in  = 1'b0;
        check("A_valid_in_handoff_cycle", 32'(frame_valid_out), 32'd0);
        @(negedge clk_in);
        check("A_valid",   32'(frame_valid_out),    32'd1);
        check("A_bank",    32'(frame_bank_out),     32'd0);
        check("A_count",   32'(frame_count_out),    32'd2);
        check("A_ovf",     32'(frame_overflow_out), 32'd0);
        blank(3);

        // B: second frame without ack, written to bank 1 and then dropped
        run_pixels(MODE_SPARSE, 1'b1, H * V);
        blank(4);
        check("B_dropped", 32'(dropped_frames_out), 32'd1);
        check("B_valid",   32'(frame_valid_out),    32'd1);
        check("B_bank",    32'(frame_bank_out),     32'd0);
        check("B_count",   32'(frame_count_out),    32'd2);

        ack_pulse();
        check("ack_clears_valid", 32'(frame_valid_out), 32'd0);

        // C: fully masked frame on bank 1, capped at capacity with overflow
        ho_q.push_back(ho_t'{bank: 1'b1, count: 9'd150, ovf: 1'b1});
        run_pixels(MODE_ALL, 1'b1, H * V);
        blank(4);
        check("C_writes_drained", 32'(wr_q.size()),       32'd0);
        check("C_count",          32'(frame_count_out),    32'd150);
        check("C_ovf",            32'(frame_overflow_out), 32'd1);
        check("C_dropped",        32'(dropped_frames_out), 32'd1);

        // D: ack asserted exactly in the HANDOFF cycle; handoff wins
        ho_q.push_back(ho_t'{bank: 1'b0, count: 9'd2, ovf: 1'b0});
        run_pixels(MODE_SPARSE, 1'b0, H * V);
        @(negedge clk_in);
        valid_in     = 1'b0;
        mask_in      = 1'b0;
        frame_ack_in = 1'b1;
        @(negedge clk_in);
        frame_ack_in = 1'b0;
        check("D_valid",   32'(frame_valid_out),    32'd1);
        check("D_bank",    32'(frame_bank_out),     32'd0);
        check("D_dropped", 32'(dropped_frames_out), 32'd1);
        blank(3);

        // E: frame restarted at (0,0) after 100 masked pixels
        ack_pulse();
        run_pixels(MODE_ALL, 1'b1, 100);
        ho_q.push_back(ho_t'{bank: 1'b1, count: 9'd2, ovf: 1'b0});
        run_pixels(MODE_SPARSE, 1'b1, H * V);
        blank(4);
        check("E_count",   32'(frame_count_out),    32'd2);
        check("E_dropped", 32'(dropped_frames_out), 32'd1);

        // F: reset in COLLECT at count 50, then a clean frame from {0,0}
        ack_pulse();
        run_pixels(MODE_ALL, 1'b0, 50);
        @(negedge clk_in);
        valid_in = 1'b0;
        mask_in  = 1'b0;
        rst_in   = 1'b0;
        @(negedge clk_in);
        check_all_zero("midframe_reset");
        rst_in = 1'b1;
        blank(2);
        ho_q.push_back(ho_t'{bank: 1'b0, count: 9'd2, ovf: 1'b0});
        run_pixels(MODE_SPARSE, 1'b0, H * V);
        blank(4);
        check("F_valid",   32'(frame_valid_out),    32'd1);
        check("F_bank",    32'(frame_bank_out),     32'd0);
        check("F_count",   32'(frame_count_out),    32'd2);
        check("F_dropped", 32'(dropped_frames_out), 32'd0);

        check("write_queue_empty",   32'(wr_q.size()), 32'd0);
        check("handoff_queue_empty", 32'(ho_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
